// File: rtl/conv_frame_ctrl_if.sv
// conv_frame_ctrl_if
// Bundles the CSR command, feeder handshake, conv/FIFO status and run status
// signals of the conv_frame_ctrl sequencer.
//   master : the sequencer (drives feeder control and run status)
//   slave  : the surrounding pixel path and CSR block
// Signals:
//   csr_start, csr_abort, csr_frames[7:0]        CSR -> sequencer
//   feed_frame_start, feed_en                     sequencer -> feeder
//   feed_valid, feed_last                         feeder -> sequencer
//   conv_valid, fifo_level[CW-1:0]                conv/FIFO -> sequencer
//   busy, done, err[2:0], frame_idx[7:0],
//   out_count[31:0], cycle_count[31:0]            sequencer -> CSR
interface conv_frame_ctrl_if #(
    parameter int CW = 11
);
    logic          csr_start;
    logic          csr_abort;
    logic [7:0]    csr_frames;
    logic          feed_frame_start;
    logic          feed_en;
    logic          feed_valid;
    logic          feed_last;
    logic          conv_valid;
    logic [CW-1:0] fifo_level;
    logic          busy;
    logic          done;
    logic [2:0]    err;
    logic [7:0]    frame_idx;
    logic [31:0]   out_count;
    logic [31:0]   cycle_count;

    modport master (
        input  csr_start, csr_abort, csr_frames,
        input  feed_valid, feed_last, conv_valid, fifo_level,
        output feed_frame_start, feed_en,
        output busy, done, err, frame_idx, out_count, cycle_count
    );

    modport slave (
        output csr_start, csr_abort, csr_frames,
        output feed_valid, feed_last, conv_valid, fifo_level,
        input  feed_frame_start, feed_en,
        input  busy, done, err, frame_idx, out_count, cycle_count
    );
endinterface

// File: rtl/conv_frame_ctrl.sv
// conv_frame_ctrl
// Run-control sequencer for the ROM -> pixel_feeder -> conv_top -> output_fifo
// path. Starts/aborts runs from CSR pulses, gates the feeder one frame at a
// time, throttles it on output FIFO fill level, counts convolved pixels to
// detect frame/run completion, and keeps a cycle count plus sticky flags.
// Ports:
//   clk      clock
//   rst      asynchronous reset, active-high
//   ctrl_io  conv_frame_ctrl_if.master: CSR commands, feeder control,
//            conv/FIFO status in, run status out
module conv_frame_ctrl #(
    parameter int IMG_W      = 640,
    parameter int IMG_H      = 960,
    parameter int FIFO_DEPTH = 1024,
    parameter int HI_MARK    = 1000,
    parameter int LO_MARK    = 512,
    parameter int DRAIN_TMO  = 4096
) (
    input  logic              clk,
    input  logic              rst,
    conv_frame_ctrl_if.master ctrl_io
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int TW = $clog2(DRAIN_TMO + 1);

    localparam logic [CW-1:0] HI_LVL    = CW'(HI_MARK);
    localparam logic [CW-1:0] LO_LVL    = CW'(LO_MARK);
    localparam logic [CW-1:0] FULL_LVL  = CW'(FIFO_DEPTH);
    localparam logic [31:0]   FRAME_PIX = 32'(IMG_W * IMG_H);
    localparam logic [TW-1:0] TMO_LAST  = TW'(DRAIN_TMO - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_FEED,
        S_DRAIN,
        S_NEXT,
        S_FINISH
    } state_t;

    state_t        state_q, state_d;
    logic          stall_q, stall_d;
    logic [7:0]    frames_q, frames_d;
    logic [7:0]    frame_idx_q, frame_idx_d;
    logic [31:0]   out_count_q, out_count_d;
    logic [31:0]   cycle_count_q, cycle_count_d;
    logic [TW-1:0] drain_cnt_q, drain_cnt_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [2:0]    err_q, err_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            stall_q       <= 1'b0;
            frames_q      <= 8'd1;
            frame_idx_q   <= '0;
            out_count_q   <= '0;
            cycle_count_q <= '0;
            drain_cnt_q   <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= '0;
        end else begin
            state_q       <= state_d;
            stall_q       <= stall_d;
            frames_q      <= frames_d;
            frame_idx_q   <= frame_idx_d;
            out_count_q   <= out_count_d;
            cycle_count_q <= cycle_count_d;
            drain_cnt_q   <= drain_cnt_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            err_q         <= err_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        stall_d       = stall_q;
        frames_d      = frames_q;
        frame_idx_d   = frame_idx_q;
        out_count_d   = out_count_q;
        cycle_count_d = cycle_count_q;
        drain_cnt_d   = '0;
        busy_d        = (state_q != S_IDLE);
        done_d        = done_q;
        err_d         = err_q;

        // Hysteresis: marks are disjoint because LO_MARK < HI_MARK.
        if (ctrl_io.fifo_level >= HI_LVL) begin
            stall_d = 1'b1;
        end else if (ctrl_io.fifo_level <= LO_LVL) begin
            stall_d = 1'b0;
        end

        if (busy_q) begin
            cycle_count_d = cycle_count_q + 32'd1;
        end

        if ((state_q == S_FEED || state_q == S_DRAIN) && ctrl_io.conv_valid &&
            (out_count_q != 32'hFFFF_FFFF)) begin
            out_count_d = out_count_q + 32'd1;
        end

        if (ctrl_io.conv_valid && (ctrl_io.fifo_level == FULL_LVL)) begin
            err_d[1] = 1'b1;
        end

        // Runs from 0 on the first DRAIN cycle.
        if (state_q == S_DRAIN) begin
            drain_cnt_d = drain_cnt_q + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                // Evaluated after the flag updates above so a start clears them.
                if (ctrl_io.csr_start) begin
                    state_d       = S_LOAD;
                    done_d        = 1'b0;
                    err_d         = '0;
                    cycle_count_d = '0;
                    frame_idx_d   = '0;
                    frames_d      = (ctrl_io.csr_frames == 8'd0) ? 8'd1 : ctrl_io.csr_frames;
                end
            end
            S_LOAD: begin
                out_count_d = '0;
                state_d     = S_FEED;
            end
            S_FEED: begin
                if (ctrl_io.feed_valid && ctrl_io.feed_last) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (out_count_q == FRAME_PIX) begin
                    state_d = S_NEXT;
                end else if (drain_cnt_q == TMO_LAST) begin
                    err_d[2] = 1'b1;
                    state_d  = S_FINISH;
                end
            end
            S_NEXT: begin
                if ({1'b0, frame_idx_q} + 9'd1 == {1'b0, frames_q}) begin
                    done_d  = 1'b1;
                    state_d = S_FINISH;
                end else begin
                    frame_idx_d = frame_idx_q + 8'd1;
                    state_d     = S_LOAD;
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort overrides whatever the state logic decided this cycle,
        // including a completion or timeout landing on the same edge.
        if (ctrl_io.csr_abort && (state_q != S_IDLE)) begin
            state_d     = S_IDLE;
            done_d      = done_q;
            frame_idx_d = frame_idx_q;
            err_d[2]    = err_q[2];
            err_d[0]    = 1'b1;
        end
    end

    assign ctrl_io.feed_frame_start = (state_q == S_LOAD);
    assign ctrl_io.feed_en          = (state_q == S_FEED) && !stall_q;
    assign ctrl_io.busy             = busy_q;
    assign ctrl_io.done             = done_q;
    assign ctrl_io.err              = err_q;
    assign ctrl_io.frame_idx        = frame_idx_q;
    assign ctrl_io.out_count        = out_count_q;
    assign ctrl_io.cycle_count      = cycle_count_q;
endmodule

// File: tb/tb_conv_frame_ctrl.sv
// tb_conv_frame_ctrl
// Directed bench for conv_frame_ctrl with a 4x3 image, 16-entry FIFO,
// marks 12/4 and a 32-cycle drain timeout. The feeder emits one pixel per
// cycle while feed_en is high; the conv model is a 2-cycle delay of
// feed_valid that can drop one chosen pixel.
module tb_conv_frame_ctrl;
    localparam int NPIX = 12;

    logic clk = 1'b0;
    logic rst = 1'b1;

    conv_frame_ctrl_if #(.CW(5)) ctrl_io ();

    conv_frame_ctrl #(
        .IMG_W(4), .IMG_H(3), .FIFO_DEPTH(16),
        .HI_MARK(12), .LO_MARK(4), .DRAIN_TMO(32)
    ) dut (
        .clk(clk),
        .rst(rst),
        .ctrl_io(ctrl_io.master)
    );

    always #5 clk = ~clk;

    // Feeder and conv models
    int   pix = 0;
    int   p1 = 0, p2 = 0;
    logic d1 = 1'b0, d2 = 1'b0;
    int   drop_idx = -1;

    assign ctrl_io.feed_valid = ctrl_io.feed_en && (pix < NPIX);
    assign ctrl_io.feed_last  = ctrl_io.feed_valid && (pix == NPIX - 1);
    assign ctrl_io.conv_valid = d2 && (p2 != drop_idx);

    always @(posedge clk) begin
        if (ctrl_io.feed_frame_start) pix <= 0;
        else if (ctrl_io.feed_valid)  pix <= pix + 1;
        d1 <= ctrl_io.feed_valid;
        p1 <= pix;
        d2 <= d1;
        p2 <= p1;
    end

    // Event monitors
    int         ffs_cnt = 0, fv_cnt = 0, cv_cnt = 0;
    logic [7:0] fidx_log [64];
    always @(posedge clk) begin
        if (ctrl_io.feed_frame_start) begin
            ffs_cnt <= ffs_cnt + 1;
            fidx_log[ffs_cnt & 63] <= ctrl_io.frame_idx;
        end
        if (ctrl_io.feed_valid) fv_cnt <= fv_cnt + 1;
        if (ctrl_io.conv_valid) cv_cnt <= cv_cnt + 1;
    end

    int total = 0;
    int bad   = 0;
    int ffs0, fv0, cv0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic snap;
        ffs0 = ffs_cnt;
        fv0  = fv_cnt;
        cv0  = cv_cnt;
    endtask

    task automatic pulse_start(input logic [7:0] f);
        ctrl_io.csr_frames = f;
        ctrl_io.csr_start  = 1'b1;
        tick;
        ctrl_io.csr_start  = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while (ctrl_io.busy !== 1'b0 && n < budget) begin
            tick;
            n++;
        end
        check({tag, "_busy_low"}, 32'(ctrl_io.busy), 32'd0);
    endtask

    initial begin
        ctrl_io.csr_start  = 1'b0;
        ctrl_io.csr_abort  = 1'b0;
        ctrl_io.csr_frames = 8'd0;
        ctrl_io.fifo_level = 5'd0;

        // Reset state
        repeat (3) tick;
        check("rst_busy", 32'(ctrl_io.busy), 32'd0);
        check("rst_done", 32'(ctrl_io.done), 32'd0);
        check("rst_err", 32'(ctrl_io.err), 32'd0);
        check("rst_feed_en", 32'(ctrl_io.feed_en), 32'd0);
        check("rst_ffs", 32'(ctrl_io.feed_frame_start), 32'd0);
        check("rst_cycles", ctrl_io.cycle_count, 32'd0);
        rst = 1'b0;
        tick;

        // 1. Nominal single frame
        snap;
        pulse_start(8'd1);
        check("t1_ffs_pulse", 32'(ctrl_io.feed_frame_start), 32'd1);
        tick;
        wait_idle("t1", 100);
        check("t1_ffs_cnt", 32'(ffs_cnt - ffs0), 32'd1);
        check("t1_fv_cnt", 32'(fv_cnt - fv0), 32'd12);
        check("t1_out_count", ctrl_io.out_count, 32'd12);
        check("t1_done", 32'(ctrl_io.done), 32'd1);
        check("t1_err", 32'(ctrl_io.err), 32'd0);
        check("t1_cycles", ctrl_io.cycle_count, 32'd18);
        check("t1_feed_en", 32'(ctrl_io.feed_en), 32'd0);

        // 2. Multi-frame, then frames=0
        snap;
        pulse_start(8'd3);
        check("t2_done_cleared", 32'(ctrl_io.done), 32'd0);
        tick;
        wait_idle("t2", 200);
        check("t2_ffs_cnt", 32'(ffs_cnt - ffs0), 32'd3);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("t2_fidx%0d", k), 32'(fidx_log[(ffs0 + k) & 63]), 32'(k));
        end
        check("t2_cv_cnt", 32'(cv_cnt - cv0), 32'd36);
        check("t2_frame_idx", 32'(ctrl_io.frame_idx), 32'd2);
        check("t2_done", 32'(ctrl_io.done), 32'd1);
        check("t2_cycles", ctrl_io.cycle_count, 32'd52);

        snap;
        pulse_start(8'd0);
        tick;
        wait_idle("t2z", 100);
        check("t2z_ffs_cnt", 32'(ffs_cnt - ffs0), 32'd1);
        check("t2z_cv_cnt", 32'(cv_cnt - cv0), 32'd12);
        check("t2z_frame_idx", 32'(ctrl_io.frame_idx), 32'd0);
        check("t2z_done", 32'(ctrl_io.done), 32'd1);

        // 3. Backpressure hysteresis
        snap;
        pulse_start(8'd1);
        tick;
        check("t3_en_before", 32'(ctrl_io.feed_en), 32'd1);
        ctrl_io.fifo_level = 5'd12;
        check("t3_en_same_cycle", 32'(ctrl_io.feed_en), 32'd1);
        tick;
        check("t3_en_hi", 32'(ctrl_io.feed_en), 32'd0);
        ctrl_io.fifo_level = 5'd5;
        tick;
        tick;
        check("t3_en_lvl5", 32'(ctrl_io.feed_en), 32'd0);
        ctrl_io.fifo_level = 5'd4;
        check("t3_en_lo_same", 32'(ctrl_io.feed_en), 32'd0);
        tick;
        check("t3_en_lo", 32'(ctrl_io.feed_en), 32'd1);
        ctrl_io.fifo_level = 5'd0;
        wait_idle("t3", 100);
        check("t3_cv_cnt", 32'(cv_cnt - cv0), 32'd12);
        check("t3_done", 32'(ctrl_io.done), 32'd1);

        // 4. Drain timeout from a dropped conv output
        drop_idx = 5;
        pulse_start(8'd1);
        tick;
        wait_idle("t4", 150);
        check("t4_err", 32'(ctrl_io.err), 32'd4);
        check("t4_done", 32'(ctrl_io.done), 32'd0);
        check("t4_out_count", ctrl_io.out_count, 32'd11);
        check("t4_cycles", ctrl_io.cycle_count, 32'd46);
        drop_idx = -1;

        // 5. Abort in FEED at pixel 6, then a clean run
        snap;
        pulse_start(8'd1);
        begin
            int n = 0;
            while ((fv_cnt - fv0) < 6 && n < 50) begin
                tick;
                n++;
            end
        end
        check("t5_fed6", 32'(fv_cnt - fv0), 32'd6);
        ctrl_io.csr_abort = 1'b1;
        tick;
        ctrl_io.csr_abort = 1'b0;
        check("t5_feed_en", 32'(ctrl_io.feed_en), 32'd0);
        check("t5_err", 32'(ctrl_io.err), 32'd1);
        check("t5_done", 32'(ctrl_io.done), 32'd0);
        wait_idle("t5", 10);
        tick;
        tick;
        snap;
        pulse_start(8'd1);
        check("t5_err_cleared", 32'(ctrl_io.err), 32'd0);
        tick;
        wait_idle("t5b", 100);
        check("t5b_done", 32'(ctrl_io.done), 32'd1);
        check("t5b_err", 32'(ctrl_io.err), 32'd0);
        check("t5b_cv_cnt", 32'(cv_cnt - cv0), 32'd12);

        // 6. Overflow keeps running; start while busy is ignored
        snap;
        pulse_start(8'd1);
        tick;
        begin
            int n = 0;
            while (ctrl_io.conv_valid !== 1'b1 && n < 20) begin
                tick;
                n++;
            end
        end
        check("t6_conv_seen", 32'(ctrl_io.conv_valid), 32'd1);
        ctrl_io.fifo_level = 5'd16;
        tick;
        ctrl_io.fifo_level = 5'd0;
        check("t6_err_ovf", 32'(ctrl_io.err), 32'd2);
        begin
            logic [7:0]  fi;
            logic [31:0] cc;
            fi = ctrl_io.frame_idx;
            cc = ctrl_io.cycle_count;
            ctrl_io.csr_frames = 8'd5;
            ctrl_io.csr_start  = 1'b1;
            tick;
            ctrl_io.csr_start  = 1'b0;
            check("t6_busy_start_fidx", 32'(ctrl_io.frame_idx), 32'(fi));
            check("t6_busy_start_cyc", ctrl_io.cycle_count, cc + 32'd1);
        end
        wait_idle("t6", 100);
        check("t6_done", 32'(ctrl_io.done), 32'd1);
        check("t6_err", 32'(ctrl_io.err), 32'd2);
        check("t6_frame_idx", 32'(ctrl_io.frame_idx), 32'd0);
        check("t6_ffs_cnt", 32'(ffs_cnt - ffs0), 32'd1);

        // Reset mid-run clears everything immediately
        pulse_start(8'd2);
        repeat (5) tick;
        rst = 1'b1;
        #1;
        check("rst_mid_busy", 32'(ctrl_io.busy), 32'd0);
        check("rst_mid_feed_en", 32'(ctrl_io.feed_en), 32'd0);
        check("rst_mid_cycles", ctrl_io.cycle_count, 32'd0);
        check("rst_mid_done", 32'(ctrl_io.done), 32'd0);
        check("rst_mid_out_count", ctrl_io.out_count, 32'd0);
        tick;
        rst = 1'b0;
        tick;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
